uart_tx_queue: RTL and testbench

//  Byte-wide transmit queue between the monitor state machine and the uart core's transmit side.
//  - Monitor pushes echo/dump bytes without polling is_transmitting.
//  - Block drains the queue into the uart one byte at a time, with a full transmit handshake and a programmable guard gap.
//  - Replaces the fixed DUMPWAIT busy-wait in the monitor; sits directly downstream of the monitor, upstream of uart.

---
 rtl/robin_uart_pkg.sv | 30 +++
 rtl/uart_tx_queue_mem.sv | 40 ++++
 rtl/uart_tx_queue.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/robin_uart_pkg.sv
// ---------------------------------------------------------------------------
// robin_uart_pkg
//  Shared definitions for the uart transmit path.
//  - seq_state_t   : 3-bit state encoding of the transmit-queue sequencer
//  - DEF_*         : default handshake timing (guard gap, start timeout)
//  - timer_width() : width of a down-counter able to hold the larger constant
// ---------------------------------------------------------------------------
package robin_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_STROBE     = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_GUARD      = 3'd5
  } seq_state_t;

  localparam int DEF_GUARD_CYCLES  = 16;
  localparam int DEF_START_TIMEOUT = 32;

  // Bits needed to count down from max(a, b); never less than one bit.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/uart_tx_queue_mem.sv
// ---------------------------------------------------------------------------
// uart_tx_queue_mem
//  Simple dual-port RAM backing the transmit queue. One write port, one read
//  port, registered read (1-cycle latency) so it maps onto block RAM.
//  A read and a write to the same address in one cycle return the old data.
// Ports:
//  clk      in   clock
//  wr_en    in   write strobe
//  wr_addr  in   write address
//  wr_data  in   write data
//  rd_en    in   read strobe; rd_data updates on the following edge
//  rd_addr  in   read address
//  rd_data  out  registered read data
// ---------------------------------------------------------------------------
module uart_tx_queue_mem #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_reg [0:(2**ADDR_WIDTH)-1];

  // No reset: contents are only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_reg[rd_addr];
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//  Byte-wide transmit queue between the monitor and the uart transmitter.
//  The monitor pushes bytes freely; a sequencer drains them one at a time
//  with a full transmit / is_transmitting handshake and a guard gap.
// Optional build macro: UART_TX_QUEUE_LEVEL_EN adds the 'level' output.
// Ports:
//  clk              in   system clock
//  rst              in   synchronous reset, active high (flushes the queue)
//  wr_en            in   push wr_data this cycle
//  wr_data          in   byte to queue
//  full             out  queue holds 2**ADDR_WIDTH bytes
//  empty            out  queue holds no bytes
//  overflow         out  sticky: a push was dropped while full
//  busy             out  queue non-empty or sequencer not idle
//  tx_byte          out  byte to the uart, stable across the handshake
//  transmit         out  single-cycle start pulse to the uart
//  is_transmitting  in   uart busy flag
//  level            out  byte count (UART_TX_QUEUE_LEVEL_EN only)
// ---------------------------------------------------------------------------
module uart_tx_queue
  import robin_uart_pkg::*;
#(
  parameter int ADDR_WIDTH    = 4,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES,
  parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              busy,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  input  logic              is_transmitting
`ifdef UART_TX_QUEUE_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0] level
`endif
);

  localparam int TW = timer_width(GUARD_CYCLES, START_TIMEOUT);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [TW-1:0]         TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0]         GUARD_LOAD = TW'(GUARD_CYCLES);
  localparam logic [TW-1:0]         START_LOAD = TW'(START_TIMEOUT);

  seq_state_t            state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  overflow_reg;
  logic [7:0]            tx_byte_reg;
  logic                  transmit_reg, transmit_next;
  logic                  load_tx;
  logic                  pop;
  logic                  push;
  logic [7:0]            mem_dout;

  assign full  = (count_reg == DEPTH_CNT);
  assign empty = (count_reg == '0);

  // The sequencer only pulls a byte while idle.
  assign pop = (state_reg == ST_IDLE) && !empty;

  // A pop in the same cycle frees a slot, so a push into a full queue still
  // lands. Read-before-write in the RAM keeps the departing byte intact.
  assign push = wr_en && (!full || pop);

  uart_tx_queue_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(8)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push),
    .wr_addr(wr_ptr_reg),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_addr(rd_ptr_reg),
    .rd_data(mem_dout)
  );

  // Queue pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      if (wr_en && !push) overflow_reg <= 1'b1;
    end
  end

  // Sequencer state, timer and uart-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      transmit_reg <= 1'b0;
      tx_byte_reg  <= 8'h00;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      transmit_reg <= transmit_next;
      if (load_tx) tx_byte_reg <= mem_dout;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    transmit_next = 1'b0;
    load_tx       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pop) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_tx    = 1'b1;
        state_next = ST_STROBE;
      end
      ST_STROBE: begin
        transmit_next = 1'b1;
        timer_next    = START_LOAD;
        state_next    = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        // Timeout covers a uart that missed the strobe or finished before
        // we could see it busy.
        if (is_transmitting) begin
          state_next = ST_WAIT_DONE;
        end else if (timer_reg == '0) begin
          state_next = ST_GUARD;
        end else begin
          timer_next = timer_reg - TIMER_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!is_transmitting) begin
          timer_next = GUARD_LOAD;
          state_next = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (timer_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg - TIMER_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign overflow = overflow_reg;
  assign busy     = !empty || (state_reg != ST_IDLE);
  assign tx_byte  = tx_byte_reg;
  assign transmit = transmit_reg;

`ifdef UART_TX_QUEUE_LEVEL_EN
  assign level = count_reg;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue
//  Self-checking bench for uart_tx_queue with a behavioural uart model and a
//  byte scoreboard. Optional macro UART_TX_QUEUE_LEVEL_EN also checks 'level'.
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int G     = 16;
  localparam int T     = 32;
  localparam int HOLD  = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       is_transmitting;
  wire        full, empty, overflow, busy, transmit;
  wire  [7:0] tx_byte;
`ifdef UART_TX_QUEUE_LEVEL_EN
  wire  [AW:0] level;
`endif

  uart_tx_queue #(
    .ADDR_WIDTH   (AW),
    .GUARD_CYCLES (G),
    .START_TIMEOUT(T)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .busy           (busy),
    .tx_byte        (tx_byte),
    .transmit       (transmit),
    .is_transmitting(is_transmitting)
`ifdef UART_TX_QUEUE_LEVEL_EN
    ,
    .level          (level)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] exp_q[$];
  int         tx_cyc[$];
  int         n_tx = 0;
  int         fall_cyc = 0;
  int         fall_count = 0;
  int         uart_mode = 0;   // 0: normal uart, 1: never goes busy
  logic       prev_tx = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Transmit monitor / scoreboard.
  always @(negedge clk) begin
    if (transmit === 1'b1) begin
      chk("tx_while_busy", {31'd0, is_transmitting}, 0);
      chk("tx_pulse_width", {31'd0, prev_tx}, 0);
      chk("tx_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      tx_cyc.push_back(cyc);
      n_tx++;
      $display("tx byte %02h at cycle %0d", tx_byte, cyc);
    end
    prev_tx = transmit;
  end

  // Uart model: busy 2 clk after the strobe, for HOLD clk.
  initial begin
    is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      if (transmit === 1'b1 && uart_mode == 0) begin
        repeat (2) @(posedge clk);
        #1 is_transmitting = 1'b1;
        repeat (HOLD) @(posedge clk);
        #1 is_transmitting = 1'b0;
        fall_cyc = cyc;
        fall_count++;
      end
    end
  end

  // Drive one byte at the current time (caller sits just after an edge).
  task automatic push(input logic [7:0] d, input bit accept, output int k);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    k     = cyc;
    wr_en = 1'b0;
    if (accept) exp_q.push_back(d);
    $display("push %02h at cycle %0d accept=%0d", d, k, accept);
  endtask

  task automatic wait_idle(input int bound, output int at_cyc);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (busy && i < bound);
    at_cyc = cyc;
    chk("idle_reached", {31'd0, busy}, 0);
  endtask

  task automatic wait_tx(input int n, input int bound);
    int i;
    i = 0;
    while (n_tx < n && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("tx_seen", {31'd0, n_tx >= n}, 1);
  endtask

  task automatic wait_ist(input logic val, input int bound);
    int i;
    i = 0;
    while (is_transmitting !== val && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("uart_busy_level", {31'd0, is_transmitting}, {31'd0, val});
  endtask

  task automatic wait_fall(input int n, input int bound);
    int i;
    i = 0;
    while (fall_count < n && i < bound) begin
      @(negedge clk);
      i++;
    end
    chk("uart_fall_seen", {31'd0, fall_count >= n}, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, idle_at, target, n_before, fc;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_transmit", {31'd0, transmit}, 0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
    chk("rst_level", {27'd0, level}, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: single byte, latency and guard gap
    @(posedge clk);
    #1;
    push(8'h41, 1, k);
    wait_tx(1, 20);
    chk("t1_latency", tx_cyc.size() > 0 ? tx_cyc[0] - k : -1, 3);
    wait_fall(1, 200);
    wait_idle(100, idle_at);
    chk("t1_busy_fall", idle_at - (fall_cyc + 1), G + 1);
    chk("t1_tx_count", n_tx, 1);

    // T2: fill the queue while the uart is busy with a lead byte
    @(posedge clk);
    #1;
    push(8'h55, 1, k);
    wait_ist(1'b1, 20);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1, k);
    @(negedge clk);
    chk("t2_full", {31'd0, full}, 1);
    chk("t2_empty", {31'd0, empty}, 0);
    chk("t2_no_overflow", {31'd0, overflow}, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
    chk("t2_level", {27'd0, level}, DEPTH);
`endif

    // T6: push exactly in the cycle the sequencer pops from a full queue
    fc = fall_count;
    wait_fall(fc + 1, 200);
    target = fall_cyc + G + 2;
    do begin
      @(posedge clk);
      #1;
    end while (cyc < target);
    push(8'hC6, 1, k);
    @(negedge clk);
    chk("t6_full", {31'd0, full}, 1);
    chk("t6_no_overflow", {31'd0, overflow}, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
    chk("t6_level", {27'd0, level}, DEPTH);
`endif

    // T3: push while full with no pop -> dropped
    @(posedge clk);
    #1;
    push(8'hAA, 0, k);
    @(negedge clk);
    chk("t3_overflow", {31'd0, overflow}, 1);
    chk("t3_full", {31'd0, full}, 1);
    wait_idle(4000, idle_at);
    chk("t3_overflow_sticky", {31'd0, overflow}, 1);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_tx_count", n_tx, 19);

    // T4: uart never goes busy -> start timeout, then next byte
    uart_mode = 1;
    n_before  = n_tx;
    @(posedge clk);
    #1;
    push(8'hB0, 1, k);
    push(8'hB1, 1, k);
    wait_idle(300, idle_at);
    chk("t4_tx_count", n_tx - n_before, 2);
    chk("t4_timeout_gap", tx_cyc.size() >= 2 ? tx_cyc[tx_cyc.size()-1] - tx_cyc[tx_cyc.size()-2] : -1, T + 5);
    uart_mode = 0;

    // T5: reset in WAIT_DONE with 5 bytes queued
    @(posedge clk);
    #1;
    push(8'h5A, 1, k);
    wait_ist(1'b1, 20);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i), 1, k);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_empty", {31'd0, empty}, 1);
    chk("t5_transmit", {31'd0, transmit}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_full", {31'd0, full}, 0);
`ifdef UART_TX_QUEUE_LEVEL_EN
    chk("t5_level", {27'd0, level}, 0);
`endif
    n_before = n_tx;
    wait_ist(1'b0, 200);
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_strobe", n_tx, n_before);
    push(8'h77, 1, k);
    wait_tx(n_before + 1, 20);
    wait_idle(300, idle_at);
    chk("t5_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
